// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
// Instruction fetch front end feeding the decoder/controller.
// It walks sequential PCs, issues reads to a 1-cycle-latency instruction
// BRAM, buffers the returned words in a small FIFO, and presents the head
// instruction with a valid/ready handshake. A redirect (taken branch or jump)
// flushes every buffered and in-flight instruction and restarts fetch at the
// new address after a one-cycle FLUSH bubble.
//
// Parameters:
//   RESET_PC    first fetch address after reset (low two bits ignored)
//   DEPTH       instruction buffer entries (>= 2)
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   imem_en     read strobe to instruction memory
//   imem_addr   byte address of the read ([1:0] always 0)
//   imem_rdata  read data, valid exactly one cycle after imem_en
//   inst_valid  head instruction available
//   inst_ready  decoder accepts the head this cycle
//   inst        head instruction word
//   opecode     inst[31:26]
//   funct       inst[5:0]
//   inst_pc     address of the head instruction
//   redirect    one-cycle pulse, jump/branch taken
//   redirect_pc new fetch address (low two bits ignored)

module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [5:0]  opecode,
  output logic [5:0]  funct,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W   = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [31:0]   ALIGN_MSK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic          inflight;
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          issue;
  logic          pop;
  logic          write;
  logic [CW:0]   occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // A redirect hides the head so the decoder cannot consume a stale word in
  // the same cycle the buffer is being thrown away.
  assign inst_valid = (count != '0) & ~redirect;
  assign pop        = inst_valid & inst_ready;

  // Any response landing in a redirect cycle belongs to the old path. Issue
  // is blocked during redirect, so nothing is ever in flight the cycle after.
  assign write      = inflight & ~redirect;

  // Slots committed: buffered entries plus the word still coming back.
  assign occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};

  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      WAIT:    state_next = RUN;
      RUN:     issue = ~redirect & (occupancy < (DEPTH_W + {{CW{1'b0}}, pop}));
      FLUSH:   state_next = RUN;
      default: state_next = WAIT;
    endcase
    if (redirect) begin
      state_next = FLUSH;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= WAIT;
      fetch_pc <= RESET_PC & ALIGN_MSK;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      if (issue) begin
        resp_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= redirect_pc & ALIGN_MSK;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // Circular buffer. Redirect only rewinds pointers and count; the stored
  // words become unreachable and are overwritten by the new path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      if (write) begin
        inst_mem[tail] <= imem_rdata;
        pc_mem[tail]   <= resp_pc;
        tail           <= ptr_inc(tail);
      end
      if (pop) begin
        head <= ptr_inc(head);
      end
      case ({write, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign inst    = inst_mem[head];
  assign inst_pc = pc_mem[head];
  assign opecode = inst[31:26];
  assign funct   = inst[5:0];

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit. Two instances share clock and reset:
//   dut_a: defaults (RESET_PC=0, DEPTH=2) for streaming, backpressure,
//          mid-stream reset and back-to-back redirects;
//   dut_b: RESET_PC=0xFFFF_FFF8, DEPTH=3 for PC wrap and a redirect taken
//          with two words buffered and one in flight.
// Stimulus pushes hand-computed head PCs into per-instance queues; monitors
// pop and compare on every accepted instruction.

module tb_inst_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_en_a, imem_en_b;
  logic [31:0] imem_addr_a, imem_addr_b;
  logic [31:0] imem_rdata_a = '0, imem_rdata_b = '0;
  logic        inst_valid_a, inst_valid_b;
  logic        ready_a = 1'b0, ready_b = 1'b0;
  logic [31:0] inst_a, inst_b;
  logic [5:0]  opecode_a, opecode_b;
  logic [5:0]  funct_a, funct_b;
  logic [31:0] inst_pc_a, inst_pc_b;
  logic        redirect_a = 1'b0, redirect_b = 1'b0;
  logic [31:0] rpc_a = '0, rpc_b = '0;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  logic        sel_b = 1'b0;
  logic [31:0] exp_a, exp_b, w_a, w_b;

  inst_fetch_unit dut_a (
    .clk(clk), .rst(rst),
    .imem_en(imem_en_a), .imem_addr(imem_addr_a), .imem_rdata(imem_rdata_a),
    .inst_valid(inst_valid_a), .inst_ready(ready_a),
    .inst(inst_a), .opecode(opecode_a), .funct(funct_a), .inst_pc(inst_pc_a),
    .redirect(redirect_a), .redirect_pc(rpc_a)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst),
    .imem_en(imem_en_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .inst_valid(inst_valid_b), .inst_ready(ready_b),
    .inst(inst_b), .opecode(opecode_b), .funct(funct_b), .inst_pc(inst_pc_b),
    .redirect(redirect_b), .redirect_pc(rpc_b)
  );

  // Memory content: word index, with address bits folded into the opcode
  // field so opecode/funct carry distinct values.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a >> 2) ^ {a[7:2], 26'd0};
  endfunction

  always @(posedge clk) begin
    if (imem_en_a) imem_rdata_a <= word_of(imem_addr_a);
    if (imem_en_b) imem_rdata_b <= word_of(imem_addr_b);
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle, drive the selected instance, return mid-cycle.
  task automatic applyStimulus(input logic rdy, input logic rd,
                               input logic [31:0] rpc);
    @(posedge clk);
    #1;
    ready_a    = sel_b ? 1'b0 : rdy;
    redirect_a = sel_b ? 1'b0 : rd;
    rpc_a      = rpc;
    ready_b    = sel_b ? rdy : 1'b0;
    redirect_b = sel_b ? rd : 1'b0;
    rpc_b      = rpc;
    @(negedge clk);
  endtask

  task automatic assertReset();
    @(posedge clk);
    #1;
    rst        = 1'b1;
    ready_a    = 1'b0;
    ready_b    = 1'b0;
    redirect_a = 1'b0;
    redirect_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Returns in the middle of cycle 0 (the WAIT cycle).
  task automatic releaseReset(input logic rdy);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    ready_a = sel_b ? 1'b0 : rdy;
    ready_b = sel_b ? rdy : 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (!rst && inst_valid_a && ready_a) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL a_unexpected: got pc %h expected none at %0t",
                 inst_pc_a, $time);
      end else begin
        exp_a = q_a.pop_front();
        w_a   = word_of(exp_a);
        checkOutput("a_pc", inst_pc_a, exp_a);
        checkOutput("a_inst", inst_a, w_a);
        checkOutput("a_opecode", 32'(opecode_a), 32'(w_a[31:26]));
        checkOutput("a_funct", 32'(funct_a), 32'(w_a[5:0]));
      end
    end
    if (!rst && inst_valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL b_unexpected: got pc %h expected none at %0t",
                 inst_pc_b, $time);
      end else begin
        exp_b = q_b.pop_front();
        w_b   = word_of(exp_b);
        checkOutput("b_pc", inst_pc_b, exp_b);
        checkOutput("b_inst", inst_b, w_b);
        checkOutput("b_opecode", 32'(opecode_b), 32'(w_b[31:26]));
        checkOutput("b_funct", 32'(funct_b), 32'(w_b[5:0]));
      end
    end
  end

  // Buffer occupancy bound.
  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      assert (dut_a.count <= 2'd2 && dut_b.count <= 2'd3)
      else begin
        n_fail++;
        $display("[TB] FAIL count_bound: got a=%0d b=%0d limit 2/3 at %0t",
                 dut_a.count, dut_b.count, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_en;
    logic [31:0] exp_addr;

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values.
    checkOutput("rst_valid", 32'(inst_valid_a), 32'd0);
    checkOutput("rst_en", 32'(imem_en_a), 32'd0);
    checkOutput("rst_inst", inst_a, 32'd0);
    checkOutput("rst_pc", inst_pc_a, 32'd0);
    checkOutput("rst_opecode", 32'(opecode_a), 32'd0);
    checkOutput("rst_funct", 32'(funct_a), 32'd0);
    checkOutput("rst_b_valid", 32'(inst_valid_b), 32'd0);
    checkOutput("rst_b_en", 32'(imem_en_b), 32'd0);

    // Streaming with inst_ready held high.
    $display("[TB] streaming");
    sel_b = 1'b0;
    for (int i = 0; i < 8; i++) q_a.push_back(32'(4 * i));
    releaseReset(1'b1);
    checkOutput("s_c0_en", 32'(imem_en_a), 32'd0);
    checkOutput("s_c0_valid", 32'(inst_valid_a), 32'd0);
    for (int c = 1; c <= 10; c++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("s_en", 32'(imem_en_a), 32'd1);
      checkOutput("s_addr", imem_addr_a, 32'(4 * (c - 1)));
      checkOutput("s_valid", 32'(inst_valid_a), 32'(c >= 3));
    end

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(inst_valid_a), 32'd0);
    checkOutput("ar_en", 32'(imem_en_a), 32'd0);
    checkOutput("s_drained", 32'(q_a.size()), 32'd0);
    ready_a = 1'b0;
    repeat (2) @(posedge clk);
    q_a.delete();

    // Backpressure: decoder stalls cycles 3..7.
    $display("[TB] backpressure");
    for (int i = 0; i < 7; i++) q_a.push_back(32'(4 * i));
    releaseReset(1'b1);
    for (int c = 1; c <= 14; c++) begin
      applyStimulus((c < 3) || (c >= 8), 1'b0, 32'd0);
      exp_en   = (c <= 2) || (c >= 8);
      exp_addr = (c <= 2) ? 32'(4 * (c - 1)) : 32'(4 * (c - 6));
      checkOutput("bp_en", 32'(imem_en_a), 32'(exp_en));
      if (exp_en) checkOutput("bp_addr", imem_addr_a, exp_addr);
      checkOutput("bp_valid", 32'(inst_valid_a), 32'(c >= 3));
      if (c >= 3 && c <= 7) begin
        checkOutput("bp_hold_pc", inst_pc_a, 32'd0);
        checkOutput("bp_hold_inst", inst_a, word_of(32'd0));
      end
    end
    assertReset();
    checkOutput("bp_drained", 32'(q_a.size()), 32'd0);
    q_a.delete();

    // dut_b: wrap from 0xFFFF_FFF8, then redirect with 2 buffered + 1 in flight.
    $display("[TB] wrap and redirect");
    sel_b = 1'b1;
    q_b.push_back(32'hFFFF_FFF8);
    q_b.push_back(32'hFFFF_FFFC);
    q_b.push_back(32'h0000_0000);
    q_b.push_back(32'h0000_0004);
    q_b.push_back(32'h0000_0100);
    q_b.push_back(32'h0000_0104);
    q_b.push_back(32'h0000_0108);
    q_b.push_back(32'h0000_010C);
    releaseReset(1'b1);
    for (int c = 1; c <= 15; c++) begin
      applyStimulus((c <= 6) || (c >= 8), c == 8, 32'h0000_0103);
      exp_en   = (c <= 7) || (c >= 10);
      exp_addr = (c <= 7) ? 32'hFFFF_FFF8 + 32'(4 * (c - 1))
                          : 32'h0000_0100 + 32'(4 * (c - 10));
      checkOutput("wr_en", 32'(imem_en_b), 32'(exp_en));
      if (exp_en) checkOutput("wr_addr", imem_addr_b, exp_addr);
      checkOutput("wr_valid", 32'(inst_valid_b),
                  32'((c >= 3 && c <= 7) || c >= 12));
    end
    assertReset();
    checkOutput("wr_drained", 32'(q_b.size()), 32'd0);
    q_b.delete();

    // Back-to-back redirects: 0x40 then 0x80; only 0x80 onward may issue.
    $display("[TB] back-to-back redirect");
    sel_b = 1'b0;
    q_a.push_back(32'h0000_0000);
    q_a.push_back(32'h0000_0004);
    q_a.push_back(32'h0000_0080);
    q_a.push_back(32'h0000_0084);
    q_a.push_back(32'h0000_0088);
    releaseReset(1'b1);
    for (int c = 1; c <= 12; c++) begin
      applyStimulus(1'b1, (c == 5) || (c == 6),
                    (c == 5) ? 32'h0000_0040 : 32'h0000_0080);
      exp_en   = (c <= 4) || (c >= 8);
      exp_addr = (c <= 4) ? 32'(4 * (c - 1)) : 32'h0000_0080 + 32'(4 * (c - 8));
      checkOutput("bb_en", 32'(imem_en_a), 32'(exp_en));
      if (exp_en) checkOutput("bb_addr", imem_addr_a, exp_addr);
      checkOutput("bb_valid", 32'(inst_valid_a), 32'((c >= 3 && c <= 4) || c >= 10));
    end
    assertReset();
    checkOutput("bb_drained", 32'(q_a.size()), 32'd0);
    q_a.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
